// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per clock, then a single sign-fix cycle; results are
// packed {remainder, quotient} for the HI/LO registers.
module seq_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] divout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state, state_d;
  logic [WIDTH-1:0]   rem, rem_d;
  logic [WIDTH-1:0]   dq, dq_d;
  logic [WIDTH-1:0]   dvs, dvs_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               neg_q, neg_q_d;
  logic               neg_r, neg_r_d;
  logic               busy_d, done_d, div_zero_d;
  logic [WIDTH-1:0]   quotient_d, remainder_d;
  logic [2*WIDTH-1:0] divout_d;

  // Scratch values for the current step / sign handling
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   dq_sh;
  logic               neg_dd, neg_dv;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Next-state and datapath update for every state
  always_comb begin
    state_d     = state;
    rem_d       = rem;
    dq_d        = dq;
    dvs_d       = dvs;
    cnt_d       = cnt;
    neg_q_d     = neg_q;
    neg_r_d     = neg_r;
    div_zero_d  = div_zero;
    quotient_d  = quotient;
    remainder_d = remainder;
    divout_d    = divout;
    rem_sh      = '0;
    dq_sh       = '0;
    neg_dd      = 1'b0;
    neg_dv      = 1'b0;
    q_fix       = '0;
    r_fix       = '0;

    case (state)
      IDLE: begin
        if (start) begin
          neg_dd  = is_signed & dividend[WIDTH-1];
          neg_dv  = is_signed & divisor[WIDTH-1];
          neg_q_d = neg_dd ^ neg_dv;
          neg_r_d = neg_dd;
          dq_d    = neg_dd ? -dividend : dividend;
          dvs_d   = neg_dv ? -divisor : divisor;
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          if (divisor == '0) begin
            // Divide by zero skips the iteration and reports raw dividend bits
            quotient_d  = '1;
            remainder_d = dividend;
            divout_d    = {dividend, {WIDTH{1'b1}}};
            div_zero_d  = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_sh = {rem, dq[WIDTH-1]};
        dq_sh  = {dq[WIDTH-2:0], 1'b0};
        if (rem_sh >= {1'b0, dvs}) begin
          rem_d    = WIDTH'(rem_sh - {1'b0, dvs});
          dq_sh[0] = 1'b1;
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
        end
        dq_d  = dq_sh;
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        q_fix       = neg_q ? -dq : dq;
        r_fix       = neg_r ? -rem : rem;
        quotient_d  = q_fix;
        remainder_d = r_fix;
        divout_d    = {r_fix, q_fix};
        div_zero_d  = 1'b0;
        state_d     = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rem       <= '0;
      dq        <= '0;
      dvs       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divout    <= '0;
    end else begin
      state     <= state_d;
      rem       <= rem_d;
      dq        <= dq_d;
      dvs       <= dvs_d;
      cnt       <= cnt_d;
      neg_q     <= neg_q_d;
      neg_r     <= neg_r_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= div_zero_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
      divout    <= divout_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider (WIDTH=32)
// against an arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic [2*W-1:0] divout;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder),
    .divout    (divout)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something unforeseen stalls the run
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: truncating division, remainder takes the dividend's sign
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic dz);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Drive one operation and observe timing and results (no checking here)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat, output int bcyc, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic [2*W-1:0] dv,
                        output logic dz, output logic done_after,
                        output logic busy_after, output logic tmo);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
    lat = 0; bcyc = 0; tmo = 1'b0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) tmo = 1'b1;
    else if (busy) bcyc++;
    q = quotient; r = remainder; dv = divout; dz = div_zero;
    @(posedge clk); #1;
    done_after = done; busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #12;
    checks++;
    if ({busy, done, div_zero, quotient, remainder, divout} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%h r=%h dv=%h, want all 0",
               busy, done, div_zero, quotient, remainder, divout);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [8] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'd5, 32'd9,
                             32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFB};
    logic [W-1:0] tb [8] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd3,
                             32'hFFFFFFFF, 32'd1, 32'd0};
    logic         ts [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] eq [8] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd3,
                             32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [W-1:0] er [8] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd0,
                             32'd0, 32'd0, 32'hFFFFFFFB};
    logic         ez [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, bcyc;
    logic [W-1:0] q, r;
    logic [2*W-1:0] dv;
    logic dz, da, ba, tmo;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], ts[i], lat, bcyc, q, r, dv, dz, da, ba, tmo);
      checks++;
      if (tmo) begin
        errors++;
        $display("FAIL dir%0d_timeout: no done within 100 edges", i);
      end
      checks++;
      if (q !== eq[i] || r !== er[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got q=%h r=%h, want q=%h r=%h", i, q, r, eq[i], er[i]);
      end
      checks++;
      if (dv !== {er[i], eq[i]}) begin
        errors++;
        $display("FAIL dir%0d_divout: got %h, want %h", i, dv, {er[i], eq[i]});
      end
      checks++;
      if (dz !== ez[i]) begin
        errors++;
        $display("FAIL dir%0d_div_zero: got %b, want %b", i, dz, ez[i]);
      end
      checks++;
      if (lat != (ez[i] ? 0 : 33) || bcyc != (ez[i] ? 1 : 34)) begin
        errors++;
        $display("FAIL dir%0d_timing: got lat=%0d busy=%0d, want lat=%0d busy=%0d",
                 i, lat, bcyc, ez[i] ? 0 : 33, ez[i] ? 1 : 34);
      end
      checks++;
      if (da !== 1'b0 || ba !== 1'b0 || div_zero !== ez[i] || quotient !== eq[i]) begin
        errors++;
        $display("FAIL dir%0d_after_done: got done=%b busy=%b dz=%b q=%h, want 0 0 %b %h",
                 i, da, ba, div_zero, quotient, ez[i], eq[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat, bcyc;
    logic [W-1:0] a, b, q, r, mq, mr;
    logic [2*W-1:0] dv;
    logic s, dz, mz, da, ba, tmo;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'd1;
        2: b = '1;
        3: b = 32'($urandom_range(1, 15));
        4: b = 32'h80000000;
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      ref_div(a, b, s, mq, mr, mz);
      run_op(a, b, s, lat, bcyc, q, r, dv, dz, da, ba, tmo);
      checks++;
      if (tmo || q !== mq || r !== mr || dv !== {mr, mq} || dz !== mz) begin
        errors++;
        $display("FAIL rand%0d_result: %h/%h s=%b got q=%h r=%h dz=%b tmo=%b, want q=%h r=%h dz=%b",
                 i, a, b, s, q, r, dz, tmo, mq, mr, mz);
      end
      checks++;
      if (lat != (mz ? 0 : 33) || da !== 1'b0 || ba !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_timing: got lat=%0d done_after=%b busy_after=%b, want lat=%0d 0 0",
                 i, lat, da, ba, mz ? 0 : 33);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bcyc, dones;
    logic [W-1:0] q, r;
    logic [2*W-1:0] dv;
    logic dz, da, ba, tmo;
    run_op(32'd1000, 32'd3, 1'b0, lat, bcyc, q, r, dv, dz, da, ba, tmo);
    @(negedge clk);
    start = 1'b1; dividend = 32'd77; divisor = 32'd5; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_zero, quotient, remainder, divout} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_clear: got busy=%b done=%b q=%h r=%h dv=%h, want all 0",
               busy, done, quotient, remainder, divout);
    end
    @(negedge clk); reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d active cycles after reset, want 0", dones);
    end
    run_op(32'd50, 32'd7, 1'b0, lat, bcyc, q, r, dv, dz, da, ba, tmo);
    checks++;
    if (tmo || q !== 32'd7 || r !== 32'd1 || lat != 33) begin
      errors++;
      $display("FAIL midrun_restart: got q=%h r=%h lat=%0d tmo=%b, want 7 1 33 0",
               q, r, lat, tmo);
    end
  endtask

  task automatic test_back_to_back();
    int n, dones;
    logic [W-1:0] q1, r1, q2, r2;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd12; divisor = 32'd5;
    @(posedge clk); #1;
    divisor = 32'd4;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    q1 = quotient; r1 = remainder;
    checks++;
    if (!done || q1 !== 32'd2 || r1 !== 32'd2) begin
      errors++;
      $display("FAIL held_first: got done=%b q=%h r=%h, want 1 2 2", done, q1, r1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_retrigger: got busy=%b, want 1", busy);
    end
    repeat (5) @(posedge clk);
    @(negedge clk); start = 1'b1; dividend = 32'd99; divisor = 32'd1;
    @(negedge clk); start = 1'b0;
    dones = 0; q2 = '0; r2 = '1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++; q2 = quotient; r2 = remainder;
      end
    end
    checks++;
    if (dones != 1 || q2 !== 32'd3 || r2 !== 32'd0) begin
      errors++;
      $display("FAIL held_second: got dones=%0d q=%h r=%h, want 1 3 0", dones, q2, r2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
